// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the HI/LO multiply/divide unit.
//   muldiv_op_t    : operation code driven by decode into the unit
//   muldiv_state_t : sequencing states of the multi-cycle engine
//   MULDIV_LATENCY : cycles from the accepting edge to the HI/LO write
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'b000,
        MD_MULT  = 3'b001,
        MD_MULTU = 3'b010,
        MD_DIV   = 3'b011,
        MD_DIVU  = 3'b100,
        MD_MTHI  = 3'b101,
        MD_MTLO  = 3'b110
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } muldiv_state_t;

    localparam int MULDIV_LATENCY = 33;

endpackage

// File: rtl/hilo_muldiv_unit_sign_fix.sv
// -----------------------------------------------------------------------------
// muldiv_sign_fix
// Combinational sign handling for the multiply/divide engine. The same block
// serves the operand latch (magnitudes) and the final write (sign restore).
//   signed_op      in  : operands are two's complement
//   a, b           in  : raw operands
//   neg_res        in  : negate product / quotient
//   neg_rem        in  : negate remainder (dividend was negative)
//   prod           in  : unsigned 2*WIDTH product
//   quot, rem      in  : unsigned quotient / remainder
//   a_mag, b_mag   out : magnitudes (raw values when unsigned)
//   prod_fix       out : signed product
//   quot_fix       out : signed quotient
//   rem_fix        out : signed remainder
// -----------------------------------------------------------------------------
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               neg_res,
    input  logic               neg_rem,
    input  logic [2*WIDTH-1:0] prod,
    input  logic [WIDTH-1:0]   quot,
    input  logic [WIDTH-1:0]   rem,
    output logic [WIDTH-1:0]   a_mag,
    output logic [WIDTH-1:0]   b_mag,
    output logic [2*WIDTH-1:0] prod_fix,
    output logic [WIDTH-1:0]   quot_fix,
    output logic [WIDTH-1:0]   rem_fix
);

    // The most negative value negates to itself, which is its correct
    // magnitude once it is treated as unsigned.
    assign a_mag    = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag    = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;

    assign prod_fix = neg_res ? (~prod + 1'b1) : prod;
    assign quot_fix = neg_res ? (~quot + 1'b1) : quot;
    assign rem_fix  = neg_rem ? (~rem + 1'b1)  : rem;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_unit
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
//   clk      in  : rising-edge clock
//   reset_n  in  : asynchronous active-low reset
//   start    in  : request strobe, ignored while busy
//   op       in  : muldiv_op_t operation
//   a        in  : multiplicand / dividend / MTHI-MTLO data
//   b        in  : multiplier / divisor
//   busy     out : operation in flight
//   done     out : one-cycle pulse after HI/LO take a mul/div result
//   hi, lo   out : HI / LO registers
//
// state | meaning
// IDLE  | waiting; accepts mul/div (to CALC) and MTHI/MTLO (immediate write)
// CALC  | one shift-add or restoring-divide step per cycle, ITER steps
// FIXUP | restore signs, write HI/LO, pulse done
// -----------------------------------------------------------------------------
module hilo_muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER + 1);

    muldiv_state_t    state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;   // product upper half / partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier then product lower half / quotient
    logic [WIDTH-1:0] opnd_b;   // multiplicand magnitude / divisor magnitude
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;

    logic             accept_md;
    logic             step_last;
    logic             is_signed_op;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;

    logic [WIDTH-1:0]   a_mag, b_mag, quot_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;

    assign is_signed_op = (op == MD_MULT) || (op == MD_DIV);
    assign accept_md    = (state == IDLE) && start &&
                          ((op == MD_MULT) || (op == MD_MULTU) ||
                           (op == MD_DIV)  || (op == MD_DIVU));
    assign step_last    = (cnt == CW'(ITER - 1));

    // Shift-add: add multiplicand to the upper half when the current
    // multiplier bit is set, then shift the whole 2*WIDTH accumulator right.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);

    // Restoring divide: bring in the next dividend bit; the 33-bit trial
    // remainder is always below twice the divisor, so the difference fits
    // back into WIDTH bits whenever it is kept.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_b});
    assign div_sub   = WIDTH'(div_shift - {1'b0, opnd_b});

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .signed_op (is_signed_op),
        .a         (a),
        .b         (b),
        .neg_res   (neg_res),
        .neg_rem   (neg_rem),
        .prod      ({acc_hi, acc_lo}),
        .quot      (acc_lo),
        .rem       (acc_hi),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .prod_fix  (prod_fix),
        .quot_fix  (quot_fix),
        .rem_fix   (rem_fix)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_md) state_next = CALC;
            CALC:    if (step_last) state_next = FIXUP;
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd_b   <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            MD_MULT, MD_MULTU: begin
                                cnt      <= '0;
                                acc_hi   <= '0;
                                acc_lo   <= b_mag;
                                opnd_b   <= a_mag;
                                is_div   <= 1'b0;
                                neg_res  <= is_signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_rem  <= 1'b0;
                                div_zero <= 1'b0;
                            end
                            MD_DIV, MD_DIVU: begin
                                cnt      <= '0;
                                acc_hi   <= '0;
                                acc_lo   <= a_mag;
                                opnd_b   <= b_mag;
                                is_div   <= 1'b1;
                                neg_res  <= is_signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_rem  <= is_signed_op && a[WIDTH-1];
                                div_zero <= (b == '0);
                            end
                            MD_MTHI: hi <= a;
                            MD_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIXUP: begin
                    done <= 1'b1;
                    if (is_div) begin
                        // With a zero divisor the remainder path already
                        // reproduces the dividend; only the quotient is forced.
                        hi <= rem_fix;
                        lo <= div_zero ? '1 : quot_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit owning the HI/LO register pair; the sequential consumer side of the combinational ALU's 64-bit MULT/DIV result path.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from decode, iterates over 32 cycles, then writes HI/LO.
- Drives busy so the pipeline stalls MFHI/MFLO and further mul/div issue until the result lands.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- ITER, WIDTH, iteration count of the CALC state.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request strobe, sampled on rising edge
- op  in  3  operation, muldiv_op_t
- a  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data
- b  in  WIDTH  rt operand: multiplier or divisor
- busy  out  1  operation in flight; start is ignored while high
- done  out  1  one-cycle pulse when HI/LO are updated by a mul/div
- hi  out  WIDTH  HI register (remainder / product upper half)
- lo  out  WIDTH  LO register (quotient / product lower half)

Behaviour:
- Reset (async, reset_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0, all internal accumulators cleared. Reset during CALC/FIXUP aborts the operation with no HI/LO write.
- States: IDLE, CALC, FIXUP.
- IDLE:
  - start=1 with MULT/MULTU/DIV/DIVU at edge E0 latches |a| and |b| (signed ops) or raw values (unsigned ops), plus the result-sign flags. Next state CALC, counter=0, busy=1 from E0.
  - start=1 with MTHI writes hi<=a at E0. MTLO writes lo<=a. busy stays 0 and done stays 0.
  - Any other op code is a no-op.
- CALC: one step per cycle, counter increments, CALC -> FIXUP after ITER steps (edges E1..E32).
  - Multiply: shift-add, 64-bit unsigned product.
  - Divide: restoring, one quotient bit per step, 33-bit partial remainder.
- FIXUP (edge E33):
  - Apply sign: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Write hi/lo, done=1 for the following cycle, busy=0, state=IDLE.
  - Latency: result visible after E33; busy high for 33 cycles.
- start while busy: ignored entirely, including MTHI/MTLO. Decode must stall on busy.
- Divide semantics: truncate toward zero.
  - Divide by zero (signed or unsigned): lo=all ones, hi=a.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
- Widths: multiply holds a 2*WIDTH accumulator. Negation uses two's complement on the full width. Absolute value of 0x80000000 is 0x80000000 treated as unsigned.
- done and an IDLE-state start on the same edge: the new op is accepted; done still pulses for the prior result.
- hi/lo hold their value at all times other than the FIXUP write or an MTHI/MTLO write.

Decomposition:
- Shared package mips_pkg:
  - muldiv_op_t enum: MD_NONE=3'b000, MD_MULT=3'b001, MD_MULTU=3'b010, MD_DIV=3'b011, MD_DIVU=3'b100, MD_MTHI=3'b101, MD_MTLO=3'b110.
  - muldiv_state_t enum: IDLE, CALC, FIXUP.
  - Constant MULDIV_LATENCY=33.
- One natural sub-module, muldiv_sign_fix: combinational abs/negate of operands and results, reused at both the latch and FIXUP stages.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 33 cycles, done pulse once, hi=0xFFFFFFFE lo=0x00000001.
- MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1. DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3 hi=1.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0. DIVU a=5 b=0 -> lo=0xFFFFFFFF hi=5.
- MTHI a=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy=0, done=0. Then MTLO a=0xCAFEF00D -> lo updated, hi unchanged.
- Issue MULTU 3*4, then at cycle 10 pulse start with MTLO a=0xDEAD and DIVU 9/3 -> both ignored; hi=0, lo=12 at done.
- Start DIVU 100/7, then drop reset_n at cycle 15 -> busy=0, done=0, hi=lo=0 immediately. After release, DIVU 100/7 -> lo=14 hi=2.
